// File: rtl/hall_position_decoder_pkg.sv
// Shared step encoding, hall lookup and drive mapping for the
// six-step commutation driver and the hall position decoder.
package hall_position_decoder_pkg;

  localparam logic [2:0] STEP_NONE = 3'd0;
  localparam logic [2:0] STEP_1    = 3'd1;
  localparam logic [2:0] STEP_2    = 3'd2;
  localparam logic [2:0] STEP_3    = 3'd3;
  localparam logic [2:0] STEP_4    = 3'd4;
  localparam logic [2:0] STEP_5    = 3'd5;
  localparam logic [2:0] STEP_6    = 3'd6;

  typedef enum logic {
    ST_UNKNOWN,
    ST_TRACKING
  } trk_state_t;

  function automatic logic [2:0] hall_to_step(
    input logic [2:0] code
  );
    case (code)
      3'b101:  return STEP_1;
      3'b100:  return STEP_2;
      3'b110:  return STEP_3;
      3'b010:  return STEP_4;
      3'b011:  return STEP_5;
      3'b001:  return STEP_6;
      default: return STEP_NONE;
    endcase
  endfunction

  function automatic logic [2:0] step_next(
    input logic [2:0] s
  );
    return (s == STEP_6) ? STEP_1 : s + 3'd1;
  endfunction

  function automatic logic [2:0] step_prev(
    input logic [2:0] s
  );
    return (s == STEP_1) ? STEP_6 : s - 3'd1;
  endfunction

  // Drive bits {ah, al, bh, bl, ch, cl}.
  function automatic logic [5:0] step_to_drive(
    input logic [2:0] s
  );
    case (s)
      STEP_1:  return 6'b10_01_00;
      STEP_2:  return 6'b10_00_01;
      STEP_3:  return 6'b00_10_01;
      STEP_4:  return 6'b01_10_00;
      STEP_5:  return 6'b01_00_10;
      STEP_6:  return 6'b00_01_10;
      default: return 6'b00_00_00;
    endcase
  endfunction

endpackage

// File: rtl/hall_input_filter.sv
// Two-flop synchronizer plus stability filter for the 3 hall lines.
// code_stb pulses when the accepted code changes.
module hall_input_filter #(
  parameter int FILTER_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] raw,
  output logic [2:0] code,
  output logic       code_stb
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_ACC = CW'(FILTER_CYCLES - 2);

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    cand;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      cand     <= '0;
      cnt      <= '0;
      code     <= '0;
      code_stb <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      code_stb <= 1'b0;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else begin
        if (cnt != CNT_MAX)
          cnt <= cnt + CW'(1);
        // accept as the counter reaches FILTER_CYCLES-1
        if (cnt == CNT_ACC && cand != code) begin
          code     <= cand;
          code_stb <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hall_position_decoder.sv
// Hall sensor position decoder: step/direction tracking, period,
// gated step rate, sticky invalid-code flag and stall detect.
module hall_position_decoder
  import hall_position_decoder_pkg::*;
#(
  parameter int FILTER_CYCLES = 16,
  parameter int GATE_CYCLES   = 50000000,
  parameter int STALL_CYCLES  = 25000000,
  parameter int PERIOD_W      = 32,
  parameter int RATE_W        = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hall_a,
  input  logic                hall_b,
  input  logic                hall_c,
  output logic [2:0]          step,
  output logic                step_valid,
  output logic                dir,
  output logic                step_pulse,
  output logic [PERIOD_W-1:0] period,
  output logic [RATE_W-1:0]   rate,
  output logic                rate_valid,
  output logic                invalid_code,
  output logic                stall
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES);

  logic [2:0]          code;
  logic                code_stb;
  logic [2:0]          new_step;
  trk_state_t          state;
  logic                adv;
  logic                fwd;
  logic                drop;
  logic                acq;
  logic [PERIOD_W-1:0] pcnt;
  logic [GW-1:0]       gate_cnt;
  logic                gate_wrap;
  logic [RATE_W-1:0]   edge_cnt;
  logic [SW-1:0]       stall_cnt;

  hall_input_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk     (clk),
    .reset   (reset),
    .raw     ({hall_a, hall_b, hall_c}),
    .code    (code),
    .code_stb(code_stb)
  );

  assign new_step = hall_to_step(code);
  assign acq = code_stb && state == ST_UNKNOWN
               && new_step != STEP_NONE;

  always_comb begin
    adv  = 1'b0;
    fwd  = 1'b0;
    drop = 1'b0;
    if (code_stb && state == ST_TRACKING) begin
      if (new_step == step_next(step)) begin
        adv = 1'b1;
        fwd = 1'b1;
      end else if (new_step == step_prev(step)) begin
        adv = 1'b1;
      end else if (new_step != step) begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_UNKNOWN;
      step         <= STEP_NONE;
      step_valid   <= 1'b0;
      dir          <= 1'b1;
      step_pulse   <= 1'b0;
      invalid_code <= 1'b0;
    end else begin
      step_pulse <= adv;
      unique case (state)
        ST_UNKNOWN: begin
          if (acq) begin
            step       <= new_step;
            step_valid <= 1'b1;
            state      <= ST_TRACKING;
          end else if (code_stb) begin
            invalid_code <= 1'b1;
          end
        end
        ST_TRACKING: begin
          if (adv) begin
            step <= new_step;
            dir  <= fwd;
          end else if (drop) begin
            step         <= STEP_NONE;
            step_valid   <= 1'b0;
            invalid_code <= 1'b1;
            state        <= ST_UNKNOWN;
          end
        end
        default: state <= ST_UNKNOWN;
      endcase
    end
  end

  // period is latched on the same edge step_pulse rises
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt   <= '0;
      period <= '0;
    end else if (adv || acq) begin
      pcnt <= '0;
      if (adv)
        period <= (&pcnt) ? pcnt : pcnt + PERIOD_W'(1);
    end else if (!(&pcnt)) begin
      pcnt <= pcnt + PERIOD_W'(1);
    end
  end

  assign gate_wrap = (gate_cnt == GATE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
    end else begin
      gate_cnt   <= gate_wrap ? '0 : gate_cnt + GW'(1);
      rate_valid <= gate_wrap;
      if (gate_wrap) begin
        rate     <= edge_cnt;
        edge_cnt <= RATE_W'(step_pulse);
      end else if (step_pulse && !(&edge_cnt)) begin
        edge_cnt <= edge_cnt + RATE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (state == ST_UNKNOWN || step_pulse)
      stall_cnt <= '0;
    else if (stall_cnt != STALL_MAX)
      stall_cnt <= stall_cnt + SW'(1);
  end

  assign stall = (stall_cnt >= STALL_MAX);

endmodule

// File: doc/hall_position_decoder.md
Name: hall_position_decoder

Overview:
- Receive-side companion to the six-step commutation driver. Samples the motor's three hall sensors and filters them. Decodes rotor position into commutation step 1..6 and reports direction.
- Measures edge-to-edge period and steps per gate window, and flags invalid codes and stalls.
- Output feeds closed-loop commutation timing and the speed display path in place of open-loop stepping.

Parameters:
- FILTER_CYCLES, 16: hall code must be stable this many clk cycles before acceptance.
- GATE_CYCLES, 50000000: rate-measurement window length (1 s at 50 MHz).
- STALL_CYCLES, 25000000: no accepted step change for this long asserts stall.
- PERIOD_W, 32: width of period counter/output.
- RATE_W, 17: width of step-rate output (matches 17-bit speed bus).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- hall_a, hall_b, hall_c  in  1 each  raw asynchronous hall inputs.
- step  out  3  current commutation step 1..6; 0 = unknown.
- step_valid  out  1  step holds a valid accepted code.
- dir  out  1  1 = forward (step increments), 0 = reverse.
- step_pulse  out  1  one-cycle pulse on each accepted step change.
- period  out  PERIOD_W  clk cycles between the last two accepted step changes.
- rate  out  RATE_W  accepted step changes counted in the last complete gate window.
- rate_valid  out  1  one-cycle pulse when rate updates.
- invalid_code  out  1  sticky: filtered code 000/111 seen, or a non-adjacent step jump.
- stall  out  1  level: no accepted step change for STALL_CYCLES.

Behaviour:
- Reset values: step=0, step_valid=0, dir=1, step_pulse=0, period=0, rate=0, rate_valid=0, invalid_code=0, stall=0. All counters cleared, synchronizers cleared to 000.
- Synchronizer: each hall input passes through a 2-flop synchronizer.
- Filter: a candidate register plus a stability counter.
  - When the synced code differs from the candidate, load the candidate and clear the counter.
  - When they match, increment the counter, saturating at FILTER_CYCLES.
  - The filtered code updates when the counter reaches FILTER_CYCLES-1.
- Decode table, code {a,b,c} to step: 101->1, 100->2, 110->3, 010->4, 011->5, 001->6.
  - 000 and 111 are invalid: step=0, step_valid=0, invalid_code set.
  - An invalid code does not update dir or period.
- Step-change FSM, states UNKNOWN and TRACKING.
  - UNKNOWN, first valid filtered step: latch step, step_valid=1, go to TRACKING. No step_pulse, no period latch; period counter restarts.
  - TRACKING, new step = old+1 (6->1 wraps): dir=1, step_pulse.
  - TRACKING, new step = old-1 (1->6 wraps): dir=0, step_pulse.
  - TRACKING, any other change: set invalid_code, go to UNKNOWN, step=0.
  - TRACKING, invalid code: set invalid_code, go to UNKNOWN.
- Period: a free-running counter clears on each step_pulse, and its prior value +1 is latched into period on that cycle. The counter saturates at all-ones (no wrap).
- Rate: the gate counter runs GATE_CYCLES cycles, then wraps.
  - The edge counter increments per step_pulse and saturates at 2^RATE_W-1.
  - On wrap, edge count goes to rate, rate_valid pulses, and the edge counter clears. A step_pulse coinciding with the wrap counts in the new window.
- Stall: a counter clears on step_pulse or in UNKNOWN. stall=1 while the count >= STALL_CYCLES. stall clears the cycle after the next step_pulse.
- invalid_code clears only on reset.
- Latency: a raw hall edge reaches step/step_pulse in 2 (sync) + FILTER_CYCLES + 1 cycles, fixed.
- Reset mid-operation: all state returns to reset values immediately (async). On release, decode starts again from UNKNOWN.

Decomposition:
- Shared package holds:
  - the step encoding constants STEP_NONE=0, STEP_1..STEP_6;
  - the hall-to-step lookup function;
  - the shared step-to-drive mapping, so driver and decoder cannot diverge.
- One natural sub-module: hall_input_filter (2-flop sync + stability filter, 3 bits wide). The decoder FSM and counters stay in the top.

Test Plan (FILTER_CYCLES=4, GATE_CYCLES=1000, STALL_CYCLES=500):
- Forward sequence: drive 101,100,110,010,011,001,101, each held 100 cycles.
  - First code: step=1, no pulse.
  - Then 6 step_pulses, dir=1, period=100 each.
  - Step reaches 1 again, so the 6->1 wrap is checked.
- Reverse sequence: from step 3, apply 100 then 101 then 001.
  - dir=0, 3 pulses, step ends at 6 (1->6 wrap).
- Glitch: while at 101, pulse to 100 for 3 cycles.
  - No step change, no pulse.
  - A 5-cycle hold is accepted, with step=2 exactly 7 cycles after the raw edge.
- Invalid/jump: at step 1, apply 111 for 10 cycles, then 110.
  - 111 sets invalid_code=1, step=0.
  - 110 re-acquires step=3 without a pulse. invalid_code stays 1.
  - Separately, jumping 1->4 also sets invalid_code.
- Rate and stall: 50 forward steps spaced 20 cycles.
  - rate=50, rate_valid pulses once per 1000 cycles.
  - Hold the code for 600 cycles: stall=1 at 500, cleared after the next step.
- Async reset: assert reset mid-sequence for 1 ns off-edge.
  - All outputs go to reset values immediately.
  - After release, the first valid code gives step without a pulse.
